branch_resolve_unit: RTL and testbench

- EX-stage branch resolution; sits directly upstream of the 2-bit prediction unit.
- Carries each ID-stage prediction into EX and compares it with the actual branch outcome.
- Raises flush/redirect on a mispredict.
- Turns resolution results into the PreRight/PreWrong pulse train the predictor needs: one-cycle pulses, each followed by a zero gap, frozen during stall.

---
 rtl/bru_pkg.sv | 22 ++
 rtl/bru_outcome_fifo.sv | 46 ++++
 rtl/branch_resolve_unit.sv | 113 +++++++++++
 tb/tb_branch_resolve_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// bru_pkg: shared emitter encoding, width defaults and predictor state constants
package bru_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int QDEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PULSE = 2'b01,
    GAP   = 2'b10
  } emitState_t;

  localparam logic [1:0] PRED_SNT = 2'b00;
  localparam logic [1:0] PRED_WNT = 2'b01;
  localparam logic [1:0] PRED_WT  = 2'b10;
  localparam logic [1:0] PRED_ST  = 2'b11;

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bru_outcome_fifo.sv
// bru_outcome_fifo: 1-bit outcome FIFO with wrap-around pointers; a push while full is dropped unless a pop frees the slot
module bru_outcome_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    din,
  output logic                    dout,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = count == (PW+1)'(DEPTH);
  assign doPop  = pop & (count != '0);
  assign doPush = push & (~full | doPop);
  assign dout   = mem[rdPtr];

  // pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= count + {{PW{1'b0}}, doPush} - {{PW{1'b0}}, doPop};
    end
  end

  // storage needs no reset: only slots covered by count are ever read
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch resolve, flush/redirect and PreRight/PreWrong pulse emitter (BRU_STATS_EN adds stat_br/stat_mis)
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              id_br_valid,
  input  logic              id_pred_taken,
  input  logic [ADDR_W-1:0] id_pc_plus4,
  input  logic [ADDR_W-1:0] id_br_target,
  input  logic              ex_br_taken,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              PreRight,
  output logic              PreWrong,
  output logic              br_q_full
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]       stat_br,
  output logic [31:0]       stat_mis
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic              exValid;
  logic              exPred;
  logic [ADDR_W-1:0] exPcPlus4;
  logic [ADDR_W-1:0] exTarget;
  logic              resolve;
  logic              mis;
  logic              qHead;
  logic [CW-1:0]     qCount;
  logic              pop;
  logic              inPulse;
  logic              nextRight;
  logic              nextWrong;
  emitState_t        state;
  emitState_t        nextState;

  assign resolve     = exValid & ~stall;
  assign mis         = exPred ^ ex_br_taken;
  assign flush       = resolve & mis;
  assign redirect_pc = flush ? (ex_br_taken ? exTarget : exPcPlus4) : '0;

  // ID->EX register: holds under stall, a flush turns the incoming branch into a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValid   <= 1'b0;
      exPred    <= 1'b0;
      exPcPlus4 <= '0;
      exTarget  <= '0;
    end else if (!stall) begin
      exValid   <= id_br_valid & ~flush;
      exPred    <= id_pred_taken;
      exPcPlus4 <= id_pc_plus4;
      exTarget  <= id_br_target;
    end
  end

  bru_outcome_fifo #(
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (resolve),
    .pop  (pop),
    .din  (~mis),
    .dout (qHead),
    .full (br_q_full),
    .count(qCount)
  );

  // emitter next state: IDLE and GAP pop into PULSE when allowed, PULSE holds under stall then yields one zero cycle
  always_comb begin
    inPulse   = state == PULSE;
    pop       = ~inPulse & (qCount != '0) & ~stall;
    nextState = inPulse ? (stall ? PULSE : GAP) : (pop ? PULSE : IDLE);
    nextRight = inPulse ? (stall & PreRight) : (pop & qHead);
    nextWrong = inPulse ? (stall & PreWrong) : (pop & ~qHead);
  end

  // emitter state and registered pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      PreRight <= 1'b0;
      PreWrong <= 1'b0;
    end else begin
      state    <= nextState;
      PreRight <= nextRight;
      PreWrong <= nextWrong;
    end
  end

`ifdef BRU_STATS_EN
  // saturating counts of resolved branches and mispredicts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br  <= '0;
      stat_mis <= '0;
    end else begin
      if (resolve) stat_br <= satInc(stat_br);
      if (flush) stat_mis <= satInc(stat_mis);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scoreboard bench for branch_resolve_unit (BRU_STATS_EN adds counter checks)
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, id_br_valid, id_pred_taken, ex_br_taken;
  logic [31:0] id_pc_plus4, id_br_target, redirect_pc;
  logic        flush, PreRight, PreWrong, br_q_full;
`ifdef BRU_STATS_EN
  logic [31:0] stat_br, stat_mis;
`endif

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   expBr  = 0;
  int   expMis = 0;
  bit   sb[$];
  logic prevPulse = 1'b0;
  logic [1:0] pat [6];

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .id_br_valid  (id_br_valid),
    .id_pred_taken(id_pred_taken),
    .id_pc_plus4  (id_pc_plus4),
    .id_br_target (id_br_target),
    .ex_br_taken  (ex_br_taken),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .PreRight     (PreRight),
    .PreWrong     (PreWrong),
    .br_q_full    (br_q_full)
`ifdef BRU_STATS_EN
    ,
    .stat_br      (stat_br),
    .stat_mis     (stat_mis)
`endif
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic expectRes(input bit right, input bit kept);
    expBr++;
    if (!right) expMis++;
    if (kept) sb.push_back(right);
  endtask

  task automatic tick();
    logic stalledEdge, pulse;
    stalledEdge = stall;
    @(posedge clk);
    #1;
    pulse = PreRight | PreWrong;
    check1("exclusive", PreRight & PreWrong, 1'b0);
    if (pulse && !prevPulse) begin
      pulses++;
      check1("pulse_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) check1("order", PreRight, sb.pop_front());
    end else if (pulse) begin
      check1("held_only_under_stall", stalledEdge, 1'b1);
    end
    prevPulse = pulse;
  endtask

  initial begin
    rst_n = 0; stall = 0; id_br_valid = 0; id_pred_taken = 0; ex_br_taken = 0;
    id_pc_plus4 = 0; id_br_target = 0;
    pat[0] = 2'b10; pat[1] = 2'b00; pat[2] = 2'b10;
    pat[3] = 2'b00; pat[4] = 2'b01; pat[5] = 2'b00;
    repeat (2) tick();
    check1("rst_right", PreRight, 1'b0);
    check1("rst_wrong", PreWrong, 1'b0);
    check1("rst_full", br_q_full, 1'b0);
    check1("rst_flush", flush, 1'b0);
    check32("rst_redirect", redirect_pc, 32'h0);
    rst_n = 1;
    tick();

    // correct taken prediction
    id_br_valid = 1; id_pred_taken = 1; id_pc_plus4 = 32'h14; id_br_target = 32'h40;
    tick();
    id_br_valid = 0; ex_br_taken = 1; expectRes(1, 1);
    #1;
    check1("t1_flush", flush, 1'b0);
    check32("t1_redirect", redirect_pc, 32'h0);
    tick(); check1("t1_not_early", PreRight, 1'b0);
    tick(); check1("t1_right", PreRight, 1'b1); check1("t1_wrong", PreWrong, 1'b0);
    tick(); check1("t1_gap", PreRight, 1'b0);
    tick();

    // mispredict with a following branch that must be bubbled
    id_br_valid = 1; id_pred_taken = 0; id_pc_plus4 = 32'h24; id_br_target = 32'h100;
    tick();
    ex_br_taken = 1; id_pred_taken = 1; expectRes(0, 1);
    #1;
    check1("t2_flush", flush, 1'b1);
    check32("t2_redirect", redirect_pc, 32'h100);
    tick();
    id_br_valid = 0; ex_br_taken = 0;
    #1;
    check1("t2_bubble", flush, 1'b0);
    check32("t2_bubble_redirect", redirect_pc, 32'h0);
    tick(); check1("t2_wrong", PreWrong, 1'b1); check1("t2_right", PreRight, 1'b0);
    tick(); check1("t2_gap", PreWrong, 1'b0);
    tick();

    // three back-to-back resolves R,R,W
    id_br_valid = 1; id_pred_taken = 1; id_pc_plus4 = 32'h30; id_br_target = 32'h80;
    tick();
    ex_br_taken = 1; expectRes(1, 1); tick();
    ex_br_taken = 1; expectRes(1, 1); tick();
    check32("t3_seq0", 32'({PreRight, PreWrong}), 32'(pat[0]));
    ex_br_taken = 0; id_br_valid = 0; expectRes(0, 1);
    #1;
    check1("t3_flush", flush, 1'b1);
    check32("t3_redirect", redirect_pc, 32'h30);
    for (int i = 1; i < 6; i++) begin
      tick();
      check32($sformatf("t3_seq%0d", i), 32'({PreRight, PreWrong}), 32'(pat[i]));
    end
    tick();

    // stall held across a pulse; the queued outcome waits
    id_br_valid = 1; id_pred_taken = 1;
    tick();
    ex_br_taken = 1; id_pred_taken = 0; expectRes(1, 1); tick();
    ex_br_taken = 1; id_br_valid = 0; expectRes(0, 1); tick();
    check32("t4_pulse", 32'({PreRight, PreWrong}), 32'h2);
    stall = 1; ex_br_taken = 0;
    repeat (3) begin
      tick();
      check32("t4_hold", 32'({PreRight, PreWrong}), 32'h2);
    end
    stall = 0;
    tick(); check32("t4_gap", 32'({PreRight, PreWrong}), 32'h0);
    tick(); check32("t4_next", 32'({PreRight, PreWrong}), 32'h1);
    tick(); check32("t4_gap2", 32'({PreRight, PreWrong}), 32'h0);
    tick();

    // fill to full, push while full is dropped, drain in order
    pulses = 0;
    id_br_valid = 1; id_pred_taken = 1; id_pc_plus4 = 32'h50; id_br_target = 32'h90;
    tick();
    for (int k = 1; k <= 9; k++) begin
      ex_br_taken = (k != 9);
      id_br_valid = (k < 9);
      expectRes(k != 9, k <= 8);
      if (k == 9) begin
        #1;
        check1("t5_flush9", flush, 1'b1);
      end
      tick();
      check1($sformatf("t5_full%0d", k), br_q_full, k >= 7);
    end
    ex_br_taken = 0;
    tick(); check1("t5_full_drain", br_q_full, 1'b0);
    repeat (10) tick();
    check32("t5_pulses", 32'(pulses), 32'd8);
    check32("t5_sb_empty", 32'(sb.size()), 32'd0);
`ifdef BRU_STATS_EN
    check32("stat_br", stat_br, 32'(expBr));
    check32("stat_mis", stat_mis, 32'(expMis));
`endif

    // reset mid-pulse with queued outcomes
    id_br_valid = 1; id_pred_taken = 1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      ex_br_taken = 1; id_br_valid = 1; id_pred_taken = (k < 6);
      expectRes(1, 1);
      tick();
    end
    check1("t6_mid_pulse", PreRight, 1'b1);
    ex_br_taken = 1; id_br_valid = 0; rst_n = 0;
    #1;
    check1("t6_rst_right", PreRight, 1'b0);
    check1("t6_rst_wrong", PreWrong, 1'b0);
    check1("t6_rst_flush", flush, 1'b0);
    check32("t6_rst_redirect", redirect_pc, 32'h0);
    check1("t6_rst_full", br_q_full, 1'b0);
`ifdef BRU_STATS_EN
    check32("t6_stat_br", stat_br, 32'h0);
    check32("t6_stat_mis", stat_mis, 32'h0);
`endif
    sb.delete();
    prevPulse = 1'b0;
    tick();
    rst_n = 1; ex_br_taken = 0; pulses = 0;
    repeat (10) tick();
    check32("t6_no_residual", 32'(pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
